// File: rtl/axis_frame_grant_mux_pkg.sv
// Shared types and helpers for axis_frame_grant_mux: FSM state encoding and
// the port-index width function used to size sel/tid.
package axis_frame_grant_mux_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        RELEASE = 2'd2
    } state_e;

    function automatic int port_idx_w(input int ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

endpackage

// File: rtl/axis_frame_grant_mux_out.sv
// Output stage of axis_frame_grant_mux: a single register by default, or a
// 2-entry skid buffer with a registered in_ready when AXIS_FRAME_GRANT_MUX_SKID_EN is defined.
module axis_frame_grant_mux_out #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

`ifdef AXIS_FRAME_GRANT_MUX_SKID_EN
    logic [1:0][W-1:0] mem_q, mem_d;
    logic              wr_q, wr_d, rd_q, rd_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              push, pop;

    // Ready comes only from the fill count, so out_ready never reaches in_ready.
    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = mem_q[rd_q];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q] = in_data;
            wr_d        = ~wr_q;
        end
        if (pop) begin
            rd_d = ~rd_q;
        end
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
`else
    logic         vld_q, vld_d;
    logic [W-1:0] data_q, data_d;

    assign in_ready  = out_ready | ~vld_q;
    assign out_valid = vld_q;
    assign out_data  = data_q;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (in_valid && in_ready) begin
            vld_d  = 1'b1;
            data_d = in_data;
        end else if (out_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end
`endif

endmodule

// File: rtl/axis_frame_grant_mux.sv
// Frame-locked AXI-Stream mux driven by an external blocking arbiter; holds one
// source until tlast. Output stage style selected by AXIS_FRAME_GRANT_MUX_SKID_EN.
module axis_frame_grant_mux
    import axis_frame_grant_mux_pkg::*;
#(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [PORTS-1:0]              s_axis_tvalid,
    output logic [PORTS-1:0]              s_axis_tready,
    input  logic [PORTS-1:0]              s_axis_tlast,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [$clog2(PORTS)-1:0]      m_axis_tid,
    output logic [PORTS-1:0]              arb_request,
    output logic [PORTS-1:0]              arb_acknowledge,
    input  logic [PORTS-1:0]              arb_grant,
    input  logic                          arb_grant_valid,
    input  logic [$clog2(PORTS)-1:0]      arb_grant_encoded
);

    localparam int             IW       = port_idx_w(PORTS);
    localparam int             W        = DATA_WIDTH + 1 + IW;
    localparam logic [IW:0]    PORT_CNT = PORTS[IW:0];

    state_e           state_q, state_d;
    logic [IW-1:0]    sel_q, sel_d;
    logic [PORTS-1:0] ack_q, ack_d;
    logic             in_valid, in_ready, in_fire;
    logic [W-1:0]     in_data, out_data;
    logic             unused_grant;

    // The one-hot grant carries nothing the encoded form does not.
    assign unused_grant    = ^arb_grant;
    assign arb_request     = s_axis_tvalid;
    assign arb_acknowledge = ack_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ack_d   = '0;
        case (state_q)
            IDLE: begin
                if (arb_grant_valid && ({1'b0, arb_grant_encoded} < PORT_CNT)) begin
                    state_d = ACTIVE;
                    sel_d   = arb_grant_encoded;
                end
            end
            ACTIVE: begin
                if (in_fire && s_axis_tlast[sel_q]) begin
                    state_d      = RELEASE;
                    ack_d[sel_q] = 1'b1;
                end
            end
            // One dead cycle so the grant the arbiter still shows is never re-latched.
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready = '0;
        in_valid      = 1'b0;
        if (state_q == ACTIVE) begin
            s_axis_tready[sel_q] = in_ready;
            in_valid             = s_axis_tvalid[sel_q];
        end
    end

    assign in_fire = in_valid & in_ready;
    assign in_data = {sel_q, s_axis_tlast[sel_q],
                      s_axis_tdata[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH]};

    axis_frame_grant_mux_out #(.W(W)) u_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready),
        .out_data  (out_data)
    );

    assign m_axis_tid   = out_data[W-1 -: IW];
    assign m_axis_tlast = out_data[DATA_WIDTH];
    assign m_axis_tdata = out_data[DATA_WIDTH-1:0];

endmodule
